lcd_pattern_sequencer: RTL and testbench
========================================

LCD_PATTERN_SEQUENCER -- requirements
Module: lcd_pattern_sequencer

Interface
REQ-001 Parameter DEB_CYCLES, default 100000: stable-level cycles required before a button level is accepted.
REQ-002 Parameter LONG_CYCLES, default 13500000: debounced hold cycles that qualify as a long press.
REQ-003 Parameter AUTO_FRAMES, default 120: frames per pattern in auto mode.
REQ-004 Parameter NUM_PAT, default 6, legal range 2..6: number of LCD test patterns.
REQ-005 Port CLK, input, 1 bit: the only clock; every flop samples on its rising edge.
REQ-006 Port nRST, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port BTN_N, input, 1 bit: raw, asynchronous user button; 0 means pressed.
REQ-008 Port LCD_VSYNC, input, 1 bit: VSYNC from the LCD timing generator, active-low, asynchronous to CLK.
REQ-009 Port PAT_SEL, output, 3 bits: current pattern index, range 0..NUM_PAT-1.
REQ-010 Port PAT_UPDATE, output, 1 bit: one-cycle pulse in the first cycle a new PAT_SEL value is visible.
REQ-011 Port AUTO_MODE, output, 1 bit: 1 means auto-cycle mode is active.
REQ-012 Port LED, output, 6 bits: active-low one-hot copy of PAT_SEL; LED[i] is 0 exactly when PAT_SEL==i.

Function
REQ-013 BTN_N and LCD_VSYNC SHALL each pass through a 2-flop synchronizer whose flops reset to 1.
REQ-014 Debounce: the counter SHALL clear whenever the synced button equals the debounced level; otherwise it increments, and on reaching DEB_CYCLES-1 the debounced level takes the synced value and the counter clears.
REQ-015 Press FSM states SHALL be IDLE, HELD and LONG; IDLE->HELD on a debounced 1->0 edge, which also clears the hold counter.
REQ-016 In HELD the hold counter SHALL increment each cycle, saturating at LONG_CYCLES.
REQ-017 HELD->IDLE on a debounced 0->1 edge before the hold counter reaches LONG_CYCLES SHALL be a short press and set the pending flag.
REQ-018 HELD->LONG when the hold counter reaches LONG_CYCLES SHALL toggle AUTO_MODE and clear the frame counter in that cycle.
REQ-019 LONG->IDLE SHALL occur only on a debounced 0->1 edge; release from LONG SHALL NOT set pending.
REQ-020 frame_start SHALL be a one-cycle internal pulse asserted in the cycle after the synced VSYNC goes 1->0.
REQ-021 In AUTO_MODE, each frame_start SHALL increment the frame counter; when it reaches AUTO_FRAMES-1, the same frame_start SHALL wrap it to 0 and request an advance.
REQ-022 The frame counter SHALL hold at 0 while AUTO_MODE is 0.
REQ-023 On frame_start with pending or an auto request, PAT_SEL SHALL advance by 1 in the next cycle, wrapping NUM_PAT-1 to 0; LED and PAT_UPDATE follow in that same cycle; pending clears.
REQ-024 PAT_SEL and LED SHALL change only in the cycle after frame_start, never mid-frame.
REQ-025 Pending is a single flag: several short presses within one frame SHALL produce exactly one advance.
REQ-026 A short press and an auto request on the same frame_start SHALL produce one advance, not two.
REQ-027 A pending flag set in the same cycle as frame_start SHALL be serviced at that frame_start.
REQ-028 Any unused encoding of the press FSM SHALL return to IDLE on the next cycle.

Reset
REQ-029 While nRST=0 at a CLK edge: PAT_SEL=0, LED=6'b111110, PAT_UPDATE=0, AUTO_MODE=0; pending, all counters and the FSM (IDLE) clear; synchronizers and debounced level load 1.
REQ-030 Asserting reset mid-press or mid-frame SHALL discard pending and hold state, so the first release after reset produces no advance.

Verification (DEB_CYCLES=4, LONG_CYCLES=20, AUTO_FRAMES=3, NUM_PAT=6)
REQ-031 Reset, then release -> PAT_SEL=0, LED=111110, AUTO_MODE=0, PAT_UPDATE=0.
REQ-032 Press held 10 cycles, released, then a VSYNC fall -> exactly one PAT_UPDATE, PAT_SEL=1, LED=111101; zero updates before the VSYNC fall.
REQ-033 BTN_N glitch of 3 cycles low -> no pending and no PAT_SEL change at the following frames.
REQ-034 Three short presses within one frame -> one advance only; six single-press frames from 0 wrap PAT_SEL back to 0.
REQ-035 Press held 30 cycles -> AUTO_MODE=1 at hold count 20 and no advance on release; then 6 frames -> PAT_SEL advances on frames 3 and 6 (to 1, then 2).
REQ-036 In auto mode, a short press released in the frame where the counter is at 2 -> a single advance at that frame_start; nRST pulsed mid-hold -> all outputs return to reset values.

Source files
------------

// File: rtl/lcd_pattern_sequencer.sv
// lcd_pattern_sequencer
//   Steps an LCD test-pattern index from a single push button. A short press
//   advances one pattern at the next frame start. A long press toggles auto
//   mode, in which the pattern advances every AUTO_FRAMES frames. Pattern
//   changes take effect only at a frame boundary, marked by the falling edge
//   of VSYNC.
// Ports
//   CLK        : system clock, rising edge
//   nRST       : synchronous active-low reset
//   BTN_N      : raw asynchronous button, 0 = pressed
//   LCD_VSYNC  : asynchronous active-low VSYNC from the LCD timing generator
//   PAT_SEL    : current pattern index, 0..NUM_PAT-1
//   PAT_UPDATE : one-cycle pulse in the first cycle of a new PAT_SEL value
//   AUTO_MODE  : 1 while auto-cycle mode is active
//   LED        : active-low one-hot copy of PAT_SEL
module lcd_pattern_sequencer #(
   parameter int unsigned DEB_CYCLES  = 100000,
   parameter int unsigned LONG_CYCLES = 13500000,
   parameter int unsigned AUTO_FRAMES = 120,
   parameter int unsigned NUM_PAT     = 6
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       BTN_N,
   input  logic       LCD_VSYNC,
   output logic [2:0] PAT_SEL,
   output logic       PAT_UPDATE,
   output logic       AUTO_MODE,
   output logic [5:0] LED
);

   localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
   localparam int unsigned FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
   localparam logic [FW-1:0] FRM_LAST = FW'(AUTO_FRAMES - 1);
   localparam logic [2:0]    PAT_LAST = 3'(NUM_PAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } press_state_t;

   press_state_t    state, state_next;
   logic            btn_s1, btn_s2, vs_s1, vs_s2, vs_d;
   logic            deb_level, deb_prev;
   logic [DW-1:0]   deb_cnt;
   logic [HW-1:0]   hold_cnt;
   logic [FW-1:0]   frm_cnt;
   logic            pending;
   logic            deb_fall, deb_rise, frame_start;
   logic            short_press, long_hit, hold_clear, hold_inc;
   logic            auto_req, advance;

   // Synchronizers, debounce and edge history
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         btn_s1    <= 1'b1;
         btn_s2    <= 1'b1;
         vs_s1     <= 1'b1;
         vs_s2     <= 1'b1;
         vs_d      <= 1'b1;
         deb_level <= 1'b1;
         deb_prev  <= 1'b1;
         deb_cnt   <= '0;
      end else begin
         btn_s1   <= BTN_N;
         btn_s2   <= btn_s1;
         vs_s1    <= LCD_VSYNC;
         vs_s2    <= vs_s1;
         vs_d     <= vs_s2;
         deb_prev <= deb_level;
         if (btn_s2 == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_level <= btn_s2;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   assign deb_fall    = deb_prev & ~deb_level;
   assign deb_rise    = ~deb_prev & deb_level;
   assign frame_start = vs_d & ~vs_s2;

   // Press FSM: state register
   always_ff @(posedge CLK) begin
      if (!nRST) state <= IDLE;
      else       state <= state_next;
   end

   // Press FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (deb_fall) state_next = HELD;
         // Reaching the long threshold wins over a release in the same cycle;
         // that release still returns to IDLE so no extra press is needed.
         HELD: begin
            if (hold_cnt == HOLD_MAX) state_next = deb_rise ? IDLE : LONG;
            else if (deb_rise)        state_next = IDLE;
         end
         LONG: if (deb_rise) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Press FSM: outputs
   always_comb begin
      short_press = 1'b0;
      long_hit    = 1'b0;
      hold_clear  = 1'b0;
      hold_inc    = 1'b0;
      case (state)
         IDLE: hold_clear = deb_fall;
         HELD: begin
            long_hit    = (hold_cnt == HOLD_MAX);
            short_press = deb_rise & (hold_cnt != HOLD_MAX);
            hold_inc    = (hold_cnt != HOLD_MAX);
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST || hold_clear) hold_cnt <= '0;
      else if (hold_inc)       hold_cnt <= hold_cnt + 1'b1;
   end

   // Auto mode and its frame counter
   assign auto_req = AUTO_MODE & frame_start & (frm_cnt == FRM_LAST);

   always_ff @(posedge CLK) begin
      if (!nRST)         AUTO_MODE <= 1'b0;
      else if (long_hit) AUTO_MODE <= ~AUTO_MODE;
   end

   always_ff @(posedge CLK) begin
      if (!nRST || !AUTO_MODE || long_hit) frm_cnt <= '0;
      else if (frame_start)                frm_cnt <= (frm_cnt == FRM_LAST) ? '0 : frm_cnt + 1'b1;
   end

   // A press completing in the frame_start cycle is serviced immediately, so
   // the flag never needs to be set at that edge.
   assign advance = frame_start & (pending | short_press | auto_req);

   always_ff @(posedge CLK) begin
      if (!nRST || frame_start) pending <= 1'b0;
      else if (short_press)     pending <= 1'b1;
   end

   // Pattern register
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         PAT_SEL    <= '0;
         PAT_UPDATE <= 1'b0;
      end else begin
         PAT_UPDATE <= advance;
         if (advance) PAT_SEL <= (PAT_SEL == PAT_LAST) ? '0 : PAT_SEL + 1'b1;
      end
   end

   always_comb begin
      LED = ~(6'b000001 << PAT_SEL);
   end

endmodule

// File: tb/tb_lcd_pattern_sequencer.sv
// tb_lcd_pattern_sequencer
//   Directed-vector bench for lcd_pattern_sequencer with small timing
//   parameters (DEB_CYCLES=4, LONG_CYCLES=20, AUTO_FRAMES=3, NUM_PAT=6).
module tb_lcd_pattern_sequencer;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       BTN_N = 1'b1;
   logic       LCD_VSYNC = 1'b1;
   logic [2:0] PAT_SEL;
   logic       PAT_UPDATE;
   logic       AUTO_MODE;
   logic [5:0] LED;

   int cmp_cnt = 0;
   int err_cnt = 0;
   int upd_cnt = 0;
   logic [5:0] led_tab [0:5] = '{6'b111110, 6'b111101, 6'b111011,
                                 6'b110111, 6'b101111, 6'b011111};

   lcd_pattern_sequencer #(
      .DEB_CYCLES (4),
      .LONG_CYCLES(20),
      .AUTO_FRAMES(3),
      .NUM_PAT    (6)
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .BTN_N     (BTN_N),
      .LCD_VSYNC (LCD_VSYNC),
      .PAT_SEL   (PAT_SEL),
      .PAT_UPDATE(PAT_UPDATE),
      .AUTO_MODE (AUTO_MODE),
      .LED       (LED)
   );

   always #5 CLK = ~CLK;

   // Count update pulses, sampled on the inactive edge
   always @(negedge CLK) if (PAT_UPDATE === 1'b1) upd_cnt = upd_cnt + 1;

   task automatic cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic press(input int n);
      BTN_N = 1'b0;
      cycles(n);
      BTN_N = 1'b1;
      cycles(12);
   endtask

   task automatic frame();
      LCD_VSYNC = 1'b0;
      cycles(4);
      LCD_VSYNC = 1'b1;
      cycles(8);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      cycles(3);
      nRST = 1'b1;
      cycles(2);
   endtask

   task automatic test_reset();
      do_reset();
      cmp_cnt++; if (PAT_SEL !== 3'd0) begin err_cnt++; $display("FAIL reset_pat got %0d want 0", PAT_SEL); end
      cmp_cnt++; if (LED !== 6'b111110) begin err_cnt++; $display("FAIL reset_led got %b want 111110", LED); end
      cmp_cnt++; if (AUTO_MODE !== 1'b0) begin err_cnt++; $display("FAIL reset_auto got %b want 0", AUTO_MODE); end
      cmp_cnt++; if (PAT_UPDATE !== 1'b0) begin err_cnt++; $display("FAIL reset_upd got %b want 0", PAT_UPDATE); end
   endtask

   task automatic test_short_press();
      int u0;
      u0 = upd_cnt;
      press(10);
      cmp_cnt++; if (upd_cnt - u0 !== 0) begin err_cnt++; $display("FAIL short_early_upd got %0d want 0", upd_cnt - u0); end
      cmp_cnt++; if (PAT_SEL !== 3'd0) begin err_cnt++; $display("FAIL short_early_pat got %0d want 0", PAT_SEL); end
      frame();
      cmp_cnt++; if (upd_cnt - u0 !== 1) begin err_cnt++; $display("FAIL short_upd got %0d want 1", upd_cnt - u0); end
      cmp_cnt++; if (PAT_SEL !== 3'd1) begin err_cnt++; $display("FAIL short_pat got %0d want 1", PAT_SEL); end
      cmp_cnt++; if (LED !== 6'b111101) begin err_cnt++; $display("FAIL short_led got %b want 111101", LED); end
      frame();
      cmp_cnt++; if (upd_cnt - u0 !== 1) begin err_cnt++; $display("FAIL short_noextra got %0d want 1", upd_cnt - u0); end
   endtask

   task automatic test_glitch();
      int u0;
      u0 = upd_cnt;
      BTN_N = 1'b0;
      cycles(3);
      BTN_N = 1'b1;
      cycles(12);
      frame();
      frame();
      cmp_cnt++; if (PAT_SEL !== 3'd1) begin err_cnt++; $display("FAIL glitch_pat got %0d want 1", PAT_SEL); end
      cmp_cnt++; if (upd_cnt - u0 !== 0) begin err_cnt++; $display("FAIL glitch_upd got %0d want 0", upd_cnt - u0); end
   endtask

   task automatic test_multi_press();
      int u0;
      u0 = upd_cnt;
      press(8);
      press(8);
      press(8);
      frame();
      cmp_cnt++; if (PAT_SEL !== 3'd2) begin err_cnt++; $display("FAIL multi_pat got %0d want 2", PAT_SEL); end
      cmp_cnt++; if (upd_cnt - u0 !== 1) begin err_cnt++; $display("FAIL multi_upd got %0d want 1", upd_cnt - u0); end
   endtask

   task automatic test_wrap();
      logic [2:0] exp;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         press(8);
         frame();
         exp = 3'((i + 1) % 6);
         cmp_cnt++; if (PAT_SEL !== exp) begin err_cnt++; $display("FAIL wrap_pat[%0d] got %0d want %0d", i, PAT_SEL, exp); end
         cmp_cnt++; if (LED !== led_tab[exp]) begin err_cnt++; $display("FAIL wrap_led[%0d] got %b want %b", i, LED, led_tab[exp]); end
      end
   endtask

   task automatic test_long_press();
      int u0;
      logic [2:0] exp_tab [0:5] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
      u0 = upd_cnt;
      BTN_N = 1'b0;
      cycles(25);
      cmp_cnt++; if (AUTO_MODE !== 1'b0) begin err_cnt++; $display("FAIL long_auto_early got %b want 0", AUTO_MODE); end
      cycles(5);
      cmp_cnt++; if (AUTO_MODE !== 1'b1) begin err_cnt++; $display("FAIL long_auto got %b want 1", AUTO_MODE); end
      BTN_N = 1'b1;
      cycles(12);
      cmp_cnt++; if (upd_cnt - u0 !== 0) begin err_cnt++; $display("FAIL long_release_upd got %0d want 0", upd_cnt - u0); end
      cmp_cnt++; if (PAT_SEL !== 3'd0) begin err_cnt++; $display("FAIL long_release_pat got %0d want 0", PAT_SEL); end
      for (int f = 0; f < 6; f++) begin
         frame();
         cmp_cnt++; if (PAT_SEL !== exp_tab[f]) begin err_cnt++; $display("FAIL auto_frame[%0d] got %0d want %0d", f + 1, PAT_SEL, exp_tab[f]); end
      end
   endtask

   task automatic test_auto_short();
      int u0;
      frame();
      frame();
      u0 = upd_cnt;
      press(10);
      frame();
      cmp_cnt++; if (PAT_SEL !== 3'd3) begin err_cnt++; $display("FAIL auto_short_pat got %0d want 3", PAT_SEL); end
      cmp_cnt++; if (upd_cnt - u0 !== 1) begin err_cnt++; $display("FAIL auto_short_upd got %0d want 1", upd_cnt - u0); end
      frame();
      cmp_cnt++; if (PAT_SEL !== 3'd3) begin err_cnt++; $display("FAIL auto_short_clear got %0d want 3", PAT_SEL); end
   endtask

   task automatic test_reset_mid();
      int u0;
      BTN_N = 1'b0;
      cycles(15);
      nRST = 1'b0;
      cycles(2);
      cmp_cnt++; if (PAT_SEL !== 3'd0) begin err_cnt++; $display("FAIL rstmid_pat got %0d want 0", PAT_SEL); end
      cmp_cnt++; if (LED !== 6'b111110) begin err_cnt++; $display("FAIL rstmid_led got %b want 111110", LED); end
      cmp_cnt++; if (AUTO_MODE !== 1'b0) begin err_cnt++; $display("FAIL rstmid_auto got %b want 0", AUTO_MODE); end
      cmp_cnt++; if (PAT_UPDATE !== 1'b0) begin err_cnt++; $display("FAIL rstmid_upd got %b want 0", PAT_UPDATE); end
      nRST = 1'b1;
      cycles(1);
      BTN_N = 1'b1;
      cycles(12);
      u0 = upd_cnt;
      frame();
      cmp_cnt++; if (PAT_SEL !== 3'd0) begin err_cnt++; $display("FAIL rstmid_release_pat got %0d want 0", PAT_SEL); end
      cmp_cnt++; if (upd_cnt - u0 !== 0) begin err_cnt++; $display("FAIL rstmid_release_upd got %0d want 0", upd_cnt - u0); end
      press(10);
      do_reset();
      frame();
      cmp_cnt++; if (PAT_SEL !== 3'd0) begin err_cnt++; $display("FAIL rst_pending_pat got %0d want 0", PAT_SEL); end
      cmp_cnt++; if (upd_cnt - u0 !== 0) begin err_cnt++; $display("FAIL rst_pending_upd got %0d want 0", upd_cnt - u0); end
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_glitch();
      test_multi_press();
      test_wrap();
      test_long_press();
      test_auto_short();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
